// File: rtl/mmio_gpio_responder_if.sv
// Data-memory bus between the core (master) and a memory-mapped responder (slave).
interface mmio_gpio_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Ready;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, Ready
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, Ready
    );
endinterface

// File: rtl/mmio_gpio_responder.sv
// GPIO block on the core's data-memory bus: 16-byte window, fixed wait states, Ready strobe,
// OUT / synchronized IN / sticky rising-edge / IRQ-enable registers.
module mmio_gpio_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned GPIO_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_gpio_responder_if.slave  bus,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  irq
);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              off_q;
    logic                    wr_q;
    logic [GPIO_WIDTH-1:0]   wdata_q;
    logic [GPIO_WIDTH-1:0]   out_q, edge_q, edge_d, irq_en_q;
    logic [GPIO_WIDTH-1:0]   sync1_q, sync2_q, prev_q;
    logic                    irq_q;
    logic                    hit, req, commit;
    logic [GPIO_WIDTH-1:0]   clr_mask;
    logic [31:0]             rd_reg;
    logic                    unused_bits;

    assign unused_bits = ^{bus.Address[1:0], bus.WriteData};

    assign hit    = bus.Address[31:4] == BASE_ADDR[31:4];
    assign req    = hit & (bus.MemWrite | bus.MemRead);
    assign commit = (state_q == StResp) && wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                // Initiator withdrew the request: abandon without side effects.
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            off_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                off_q   <= bus.Address[3:2];
                wr_q    <= bus.MemWrite;
                wdata_q <= bus.WriteData[GPIO_WIDTH-1:0];
            end
        end
    end

    // A new rising edge outranks a W1C clear landing in the same cycle.
    assign clr_mask = (commit && off_q == 2'd2) ? wdata_q : '0;
    assign edge_d   = (edge_q & ~clr_mask) | (sync2_q & ~prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            out_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= edge_d;
            irq_q   <= |(edge_q & irq_en_q);
            if (commit && off_q == 2'd0) out_q    <= wdata_q;
            if (commit && off_q == 2'd3) irq_en_q <= wdata_q;
        end
    end

    always_comb begin
        rd_reg = '0;
        unique case (off_q)
            2'd0: rd_reg[GPIO_WIDTH-1:0] = out_q;
            2'd1: rd_reg[GPIO_WIDTH-1:0] = sync2_q;
            2'd2: rd_reg[GPIO_WIDTH-1:0] = edge_q;
            2'd3: rd_reg[GPIO_WIDTH-1:0] = irq_en_q;
            default: rd_reg = '0;
        endcase
    end

    assign bus.Ready    = (state_q == StResp);
    assign bus.ReadData = bus.Ready ? rd_reg : 32'h0;
    assign gpio_out     = out_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_mmio_gpio_responder.sv
// Directed bench for mmio_gpio_responder (BASE 0x1001_0000, one wait state, 8 GPIO bits).
module tb_mmio_gpio_responder;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;
    logic [7:0]  gin;
    logic [31:0] rdata;
    int          lat;
    int          rdy_cnt;
    int          n_asserts = 0;
    int          n_fail = 0;

    mmio_gpio_responder_if bus ();

    mmio_gpio_responder #(
        .BASE_ADDR  (BASE),
        .WAIT_STATES(1),
        .GPIO_WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction; gpio_in takes 'gin' in the same cycle the request appears.
    task automatic xact(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic re, output logic [31:0] rd, output int l);
        @(posedge clk); #1;
        bus.Address   = addr;
        bus.WriteData = wdata;
        bus.MemWrite  = we;
        bus.MemRead   = re;
        gpio_in       = gin;
        l  = -1;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Ready) begin
                l  = i;
                rd = bus.ReadData;
                break;
            end
        end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] v, input int cycles);
        @(posedge clk); #1;
        gin     = v;
        gpio_in = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        gin           = 8'h00;
        gpio_in       = 8'h00;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.Ready}, 32'h0);
        chk("rst_rdata", bus.ReadData, 32'h0);
        chk("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // OUT write: Ready two cycles after request, output visible after RESP.
        xact(BASE + 32'h0, 32'h0000_00A5, 1'b1, 1'b0, rdata, lat);
        chk("wr_out_lat", 32'(lat), 32'd2);
        chk("wr_out_gpio", {24'b0, gpio_out}, 32'hA5);
        @(negedge clk);
        chk("idle_rdata_zero", bus.ReadData, 32'h0);
        xact(BASE + 32'h0, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("rd_out", rdata, 32'hA5);
        chk("rd_out_lat", 32'(lat), 32'd2);

        // Synchronized IN, and the edges it produced on bits 2..5.
        set_in(8'h3C, 3);
        xact(BASE + 32'h4, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("rd_in", rdata, 32'h3C);
        xact(BASE + 32'h4, 32'hFF, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'h4, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("in_write_ignored", rdata, 32'h3C);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_3c", rdata, 32'h3C);
        xact(BASE + 32'h8, 32'hFF, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_w1c_all", rdata, 32'h0);

        // IRQ on bit 0 rise, cleared through W1C.
        xact(BASE + 32'hC, 32'h01, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'hC, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("irq_en_rd", rdata, 32'h01);
        chk("irq_before", {31'b0, irq}, 32'h0);
        set_in(8'h3D, 5);
        chk("irq_set", {31'b0, irq}, 32'h1);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_bit0", rdata, 32'h01);
        xact(BASE + 32'h8, 32'h01, 1'b1, 1'b0, rdata, lat);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        // Bit 1: rise synchronized into the same cycle as its W1C -> flag survives.
        set_in(8'h3F, 4);
        set_in(8'h3D, 4);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_bit1_pre", rdata, 32'h02);
        gin = 8'h3F;
        xact(BASE + 32'h8, 32'h02, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_set_wins", rdata, 32'h02);
        xact(BASE + 32'h8, 32'h02, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'h8, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("edge_bit1_clr", rdata, 32'h0);
        chk("irq_masked", {31'b0, irq}, 32'h0);

        // Out-of-window write: no Ready, nothing changes.
        @(posedge clk); #1;
        bus.Address   = 32'h2000_0000;
        bus.WriteData = 32'hFF;
        bus.MemWrite  = 1'b1;
        rdy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Ready) rdy_cnt++;
        end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        chk("oow_no_ready", 32'(rdy_cnt), 32'd0);
        chk("oow_gpio_out", {24'b0, gpio_out}, 32'hA5);

        // Upper bits read back as zero.
        xact(BASE + 32'hC, 32'hFFFF_FF03, 1'b1, 1'b0, rdata, lat);
        xact(BASE + 32'hC, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("irq_en_width", rdata, 32'h03);

        // Write+read together: treated as write, returns old value.
        xact(BASE + 32'h0, 32'h5A, 1'b1, 1'b1, rdata, lat);
        chk("rw_old_value", rdata, 32'hA5);
        chk("rw_new_out", {24'b0, gpio_out}, 32'h5A);

        // Request withdrawn during WAIT: aborted, no write.
        @(posedge clk); #1;
        bus.Address   = BASE;
        bus.WriteData = 32'h11;
        bus.MemWrite  = 1'b1;
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        rdy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.Ready) rdy_cnt++;
        end
        chk("abort_no_ready", 32'(rdy_cnt), 32'd0);
        chk("abort_no_write", {24'b0, gpio_out}, 32'h5A);

        // Reset asserted in WAIT of a write OUT=0xFF.
        @(posedge clk); #1;
        bus.Address   = BASE;
        bus.WriteData = 32'hFF;
        bus.MemWrite  = 1'b1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, bus.Ready}, 32'h0);
        chk("rst_mid_gpio_out", {24'b0, gpio_out}, 32'h0);
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready2", {31'b0, bus.Ready}, 32'h0);
        xact(BASE + 32'h0, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("rst_mid_out_rd", rdata, 32'h0);
        xact(BASE + 32'hC, 32'h0, 1'b0, 1'b1, rdata, lat);
        chk("rst_mid_irq_en", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
